sha256_pad: RTL
===============

# sha256_pad

SHA-256 message padder: accepts a byte stream and emits the padded 32-bit big-endian word stream that the `sha256` core consumes on its `in_*` interface. It sits directly upstream of `sha256` and is the transmitter for that interface. It performs FIPS 180-4 padding: append `0x80`, append zeros up to 448 mod 512 bits, then append the 64-bit bit length. `out_last_o` marks the final word of the final block.

## Interface
- `I_WIDTH`, 8, input data width in bits; fixed at 8 (one byte per beat).
- `O_WIDTH`, 32, output word width in bits; matches `sha256` `in_data_i`.
- `C_WIDTH`, 61, message byte-counter width; bit length is `{cnt, 3'b000}`, 64 bits.
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `in_data_i` in 8: message byte.
- `in_last_i` in 1: marks the final byte of a message; qualified by the handshake.
- `in_valid_i` in 1: byte valid.
- `in_ready_o` out 1: byte accepted when `in_valid_i && in_ready_o`.
- `out_data_o` out 32: padded word; first byte of the word is in [31:24].
- `out_last_o` out 1: high on word 15 of the final block.
- `out_valid_o` out 1: word valid.
- `out_ready_i` in 1: word consumed when `out_valid_o && out_ready_i`.

## Operation
- **Output register.** A single output register holds `out_data_o`, `out_last_o` and `out_valid_o`.
  - It is "free" when `!out_valid_o || out_ready_i`.
  - A new word is loaded only when the register is free.
- **Counters.**
  - `b` (0..3): byte position in the word being assembled.
  - `w` (0..15, wraps): index of the next word to load.
  - `cnt` (61 bits): bytes accepted in the current message; wraps mod 2^61.
- **State machine.**
  - S_DATA:
    - `in_ready_o = out_valid_o ? out_ready_i : 1`.
    - An accepted byte is written to byte lane `b`, and `cnt` increments.
    - Non-last byte with `b==3`: load the assembled word, `w++`, `b=0`.
    - Last byte with `b==3`: load the word, go to S_PAD80.
    - Last byte with `b<3`: load the word with `0x80` in lane `b+1` and zeros below it, then go to S_ZERO.
  - S_PAD80: load `0x8000_0000`, `w++`, go to S_ZERO.
  - S_ZERO:
    - If `w==14`: load `len[63:32]`, go to S_LEN_LO.
    - Otherwise: load `0x0000_0000`, `w++`. Wrapping 15→0 starts a new block.
  - S_LEN_LO: load `len[31:0]` with `out_last_o=1`, clear `w`, `b` and `cnt`, go to S_DATA.
- **Length value.** `len = {cnt, 3'b000}` is taken from `cnt` after the last byte has been counted.
- **Input blocked during padding.** `in_ready_o = 0` in every state other than S_DATA.
- **Zero-length messages** are not supported; every message has at least 1 byte.

## Timing
- **Reset values:**
  - `out_valid_o=0`, `out_last_o=0`, `out_data_o=0`.
  - State is S_DATA; all counters are 0.
  - `in_ready_o=1` once reset is released; it is 0 while `rst_n_i` is low.
- **Latency.** A word appears on `out_valid_o` one cycle after the accept of the byte that completes it.
- **Throughput.**
  - Input: 1 byte/cycle.
  - Padding words: 1/cycle when `out_ready_i=1`.
- **Output hold.** While `out_valid_o && !out_ready_i`, `out_data_o` and `out_last_o` hold, and all state and counters freeze.
- **Boundary cases (message length n bytes):**
  - n mod 64 ≤ 55: one pad block.
  - n mod 64 ≥ 56: an extra block containing only zeros and the length.
  - `out_last_o` is never asserted on a non-final block.
- **Back-to-back messages.** The next message's first byte may be accepted in the cycle after the S_LEN_LO word is loaded.
- **Reset mid-operation.** Asserting `rst_n_i` low clears all outputs and state immediately, with no partial word emitted afterward.

## Structure
- **`sha256_pkg`** holds:
  - the state enum (S_DATA, S_PAD80, S_ZERO, S_LEN_LO);
  - `PAD_BYTE=8'h80`;
  - `BLK_WORDS=16`;
  - `LEN_HI_IDX=14`.
- **No sub-module.** The byte packer and FSM live in one module. Connection to `sha256` is done by the parent.

## Test plan
- **"abc", `out_ready_i=1`:** expect 16 words: `0x6162_6380`, 13×`0`, `0`, then `0x0000_0018` with `out_last_o=1`. The first word is valid the cycle after the 3rd accept.
- **55 bytes:** expect one block. Word 13 = bytes 52–54 followed by `0x80`. Word 15 = `0x0000_01B8`, last.
- **56 bytes:** expect 32 words.
  - Word 14 = `0x8000_0000`, word 15 = `0`, with `out_last_o=0`.
  - Words 16–30 = `0`.
  - Word 31 = `0x0000_01C0`, last.
- **64 bytes:** word 16 = `0x8000_0000`; word 31 = `0x0000_0200`, last; `in_ready_o=0` throughout words 16–31.
- **"abc" with random `out_ready_i` (50%):** the word sequence is identical to the first scenario. Data and last are stable while stalled. `in_ready_o=0` whenever the register is full and `out_ready_i=0`.
- **Reset mid-run:** pulse `rst_n_i` low during S_ZERO. `out_valid_o` goes to 0 immediately. A following "abc" yields exactly the first scenario's 16 words.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// States, pad byte and block geometry used by sha256_pad.
package sha256_pkg;

  typedef enum logic [1:0] {
    S_DATA,
    S_PAD80,
    S_ZERO,
    S_LEN_LO
  } state_t;

  localparam logic [7:0] PAD_BYTE   = 8'h80;
  localparam int         BLK_WORDS  = 16;
  localparam int         LEN_HI_IDX = 14;

endpackage

// File: rtl/sha256_pad.sv
// FIPS 180-4 padder: bytes in, padded big-endian 32-bit words out, one register stage.
// Word valid one cycle after completing byte; input blocked while output is stalled or padding.
module sha256_pad
  import sha256_pkg::*;
#(
  parameter int I_WIDTH = 8,
  parameter int O_WIDTH = 32,
  parameter int C_WIDTH = 61
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [I_WIDTH-1:0] in_data_i,
  input  logic               in_last_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [O_WIDTH-1:0] out_data_o,
  output logic               out_last_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  localparam int                  W_BITS = $clog2(BLK_WORDS);
  localparam logic [W_BITS-1:0]   W_ONE  = 1;
  localparam logic [C_WIDTH-1:0]  C_ONE  = 1;

  state_t               state_q, state_d;
  logic [1:0]           b_q, b_d;
  logic [W_BITS-1:0]    w_q, w_d;
  logic [C_WIDTH-1:0]   cnt_q, cnt_d;
  logic [23:0]          pack_q, pack_d;
  logic [O_WIDTH-1:0]   odata_q, odata_d;
  logic                 olast_q, olast_d;
  logic                 ovalid_q, ovalid_d;

  logic                 free;
  logic                 load;
  logic                 load_last;
  logic [O_WIDTH-1:0]   load_word;
  logic [O_WIDTH-1:0]   asm_word;
  logic [31:0]          pack32;
  logic [1:0]           li;
  logic [C_WIDTH+2:0]   len;

  assign len         = {cnt_q, 3'b000};
  assign pack32      = {pack_q, 8'h00};
  assign free        = !ovalid_q || out_ready_i;
  assign in_ready_o  = rst_n_i && (state_q == S_DATA) && free;
  assign out_data_o  = odata_q;
  assign out_last_o  = olast_q;
  assign out_valid_o = ovalid_q;

  // Lanes below b come from earlier bytes, lane b is the incoming byte, and a
  // final short word gets the pad byte right after it with zeros beyond.
  always_comb begin
    asm_word = '0;
    li       = '0;
    for (int i = 0; i < 4; i++) begin
      li = 2'(i);
      if (li < b_q)
        asm_word[31-8*i -: 8] = pack32[31-8*i -: 8];
      else if (li == b_q)
        asm_word[31-8*i -: 8] = in_data_i;
      else if (in_last_i && li == b_q + 2'd1)
        asm_word[31-8*i -: 8] = PAD_BYTE;
      else
        asm_word[31-8*i -: 8] = 8'h00;
    end
  end

  always_comb begin
    state_d   = state_q;
    b_d       = b_q;
    w_d       = w_q;
    cnt_d     = cnt_q;
    pack_d    = pack_q;
    load      = 1'b0;
    load_last = 1'b0;
    load_word = '0;

    case (state_q)
      S_DATA: begin
        if (in_valid_i && in_ready_o) begin
          cnt_d  = cnt_q + C_ONE;
          pack_d = asm_word[31:8];
          if (b_q == 2'd3 || in_last_i) begin
            load      = 1'b1;
            load_word = asm_word;
            w_d       = w_q + W_ONE;
            b_d       = 2'd0;
            if (in_last_i)
              state_d = (b_q == 2'd3) ? S_PAD80 : S_ZERO;
          end else begin
            b_d = b_q + 2'd1;
          end
        end
      end
      S_PAD80: begin
        if (free) begin
          load      = 1'b1;
          load_word = {PAD_BYTE, 24'h000000};
          w_d       = w_q + W_ONE;
          state_d   = S_ZERO;
        end
      end
      S_ZERO: begin
        if (free) begin
          load = 1'b1;
          if (w_q == W_BITS'(LEN_HI_IDX)) begin
            load_word = len[63:32];
            state_d   = S_LEN_LO;
          end else begin
            load_word = '0;
            w_d       = w_q + W_ONE;
          end
        end
      end
      S_LEN_LO: begin
        if (free) begin
          load      = 1'b1;
          load_last = 1'b1;
          load_word = len[31:0];
          w_d       = '0;
          b_d       = 2'd0;
          cnt_d     = '0;
          state_d   = S_DATA;
        end
      end
      default: state_d = S_DATA;
    endcase
  end

  always_comb begin
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    olast_d  = olast_q;
    if (free) begin
      ovalid_d = load;
      if (load) begin
        odata_d = load_word;
        olast_d = load_last;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_DATA;
      b_q      <= '0;
      w_q      <= '0;
      cnt_q    <= '0;
      pack_q   <= '0;
      odata_q  <= '0;
      olast_q  <= 1'b0;
      ovalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      b_q      <= b_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      odata_q  <= odata_d;
      olast_q  <= olast_d;
      ovalid_q <= ovalid_d;
    end
  end

endmodule
